// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the memory bus responder.
// The parity option is enabled with MEM_BUS_RESPONDER_PARITY_EN.
package mem_bus_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } fsm_state_t;

  localparam logic [15:0] DEFAULT_BASE_ADDR  = 16'h2000;
  localparam int          DEFAULT_SIZE_WORDS = 1024;

  localparam logic BW_BYTE = 1'b1;
  localparam logic BW_WORD = 1'b0;

  // Even parity: the stored bit makes the total count of ones even.
  function automatic logic even_par(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/ram_byte_lanes.sv
// Two-lane word RAM with per-lane write enables and a registered read port.
// LW is the lane width (8, or 9 when a parity bit rides along with each byte).
module ram_byte_lanes #(
  parameter int AW = 10,
  parameter int LW = 8
) (
  input  logic          clk,
  input  logic [AW-1:0] waddr,
  input  logic          we_lo,
  input  logic          we_hi,
  input  logic [LW-1:0] wdata_lo,
  input  logic [LW-1:0] wdata_hi,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [LW-1:0] rdata_lo,
  output logic [LW-1:0] rdata_hi
);

  logic [LW-1:0] mem_lo [2**AW];
  logic [LW-1:0] mem_hi [2**AW];

  always_ff @(posedge clk) begin
    if (we_lo) mem_lo[waddr] <= wdata_lo;
    if (we_hi) mem_hi[waddr] <= wdata_hi;
    if (re) begin
      rdata_lo <= mem_lo[raddr];
      rdata_hi <= mem_hi[raddr];
    end
  end

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side bus responder: window decode, byte/word writes, one-cycle read
// latency and a post-reset zero-fill. Optional parity via MEM_BUS_RESPONDER_PARITY_EN.
module mem_bus_responder
  import mem_bus_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR  = DEFAULT_BASE_ADDR,
  parameter int          SIZE_WORDS = DEFAULT_SIZE_WORDS
) (
  input  logic        MCLK,
  input  logic        reset,
  input  logic [15:0] MAB,
  input  logic [15:0] MDBout,
  input  logic        BW,
  input  logic        MW,
`ifdef MEM_BUS_RESPONDER_PARITY_EN
  input  logic        PINJ,
  output logic        PERR,
`endif
  output logic [15:0] MDBin,
  output logic        SEL,
  output logic        BUSY
);

  localparam int AW = $clog2(SIZE_WORDS);
  localparam logic [16:0] END_ADDR = 17'(BASE_ADDR) + 17'(2 * SIZE_WORDS);
  localparam logic [AW-1:0] LAST_FILL = AW'(SIZE_WORDS - 1);
`ifdef MEM_BUS_RESPONDER_PARITY_EN
  localparam int LW = 9;
`else
  localparam int LW = 8;
`endif

  fsm_state_t state, state_next;
  logic [AW-1:0] fill, fill_next;

  logic          hit, run, word_acc, lane, cpu_wr, cpu_rd;
  logic [AW:0]   offset;
  logic [AW-1:0] idx;

  logic          we_lo, we_hi;
  logic [AW-1:0] waddr;
  logic [7:0]    lo_byte, hi_byte;
  logic          inj;
  logic [LW-1:0] wdata_lo, wdata_hi, rdata_lo, rdata_hi;

  logic rd_q, word_q, lane_q, sel_q;

  // Upper bound is compared at 17 bits so a window ending at 16'hFFFF+1 decodes correctly.
  assign hit      = (MAB >= BASE_ADDR) && ({1'b0, MAB} < END_ADDR);
  assign offset   = (AW + 1)'(MAB - BASE_ADDR);
  assign idx      = offset[AW:1];
  assign lane     = offset[0];
  assign run      = (state == ST_RUN);
  assign word_acc = (BW == BW_WORD);
  assign cpu_wr   = run & MW & hit;
  assign cpu_rd   = run & ~MW & hit;

  always_comb begin
    state_next = state;
    fill_next  = fill;
    if (state == ST_INIT) begin
      fill_next = fill + 1'b1;
      if (fill == LAST_FILL) state_next = ST_RUN;
    end
  end

  always_ff @(posedge MCLK) begin
    if (reset) begin
      state <= ST_INIT;
      fill  <= '0;
    end else begin
      state <= state_next;
      fill  <= fill_next;
    end
  end

  // Write port: zero-fill owns it during INIT, the CPU during RUN.
  always_comb begin
    we_lo   = 1'b1;
    we_hi   = 1'b1;
    waddr   = fill;
    lo_byte = 8'h00;
    hi_byte = 8'h00;
    inj     = 1'b0;
    if (run) begin
      we_lo   = cpu_wr & (word_acc | ~lane);
      we_hi   = cpu_wr & (word_acc | lane);
      waddr   = idx;
      lo_byte = MDBout[7:0];
      hi_byte = word_acc ? MDBout[15:8] : MDBout[7:0];
`ifdef MEM_BUS_RESPONDER_PARITY_EN
      inj     = PINJ;
`endif
    end
  end

`ifdef MEM_BUS_RESPONDER_PARITY_EN
  assign wdata_lo = {even_par(lo_byte) ^ inj, lo_byte};
  assign wdata_hi = {even_par(hi_byte) ^ inj, hi_byte};
`else
  assign wdata_lo = lo_byte;
  assign wdata_hi = hi_byte;
  logic unused_inj;
  assign unused_inj = inj;
`endif

  ram_byte_lanes #(.AW(AW), .LW(LW)) u_ram (
    .clk      (MCLK),
    .waddr    (waddr),
    .we_lo    (we_lo),
    .we_hi    (we_hi),
    .wdata_lo (wdata_lo),
    .wdata_hi (wdata_hi),
    .re       (cpu_rd),
    .raddr    (idx),
    .rdata_lo (rdata_lo),
    .rdata_hi (rdata_hi)
  );

  always_ff @(posedge MCLK) begin
    if (reset) begin
      rd_q   <= 1'b0;
      word_q <= 1'b0;
      lane_q <= 1'b0;
      sel_q  <= 1'b0;
    end else begin
      rd_q   <= cpu_rd;
      word_q <= word_acc;
      lane_q <= lane;
      sel_q  <= hit;
    end
  end

  // Only a RUN read hit drives data; everything else drives zero for the external OR.
  always_comb begin
    MDBin = 16'h0000;
    if (rd_q) begin
      if (word_q)      MDBin = {rdata_hi[7:0], rdata_lo[7:0]};
      else if (lane_q) MDBin = {8'h00, rdata_hi[7:0]};
      else             MDBin = {8'h00, rdata_lo[7:0]};
    end
  end

`ifdef MEM_BUS_RESPONDER_PARITY_EN
  logic err_lo, err_hi;
  assign err_lo = ^rdata_lo;
  assign err_hi = ^rdata_hi;
  assign PERR   = rd_q & (word_q ? (err_lo | err_hi) : (lane_q ? err_hi : err_lo));
`endif

  assign SEL  = sel_q;
  assign BUSY = (state == ST_INIT);

endmodule
